pipe_scoreboard: RTL and testbench

- Parametrised hazard/forwarding scoreboard for the pipelined CPU; sits alongside RegDecode.
- Tracks in-flight register writes for DEPTH post-decode stages (default EX, MEM, WR).
- Generates per-operand forwarding selects, load-use stall, flush bubbles and a saturating stall counter.
- Generalises the fixed two-stage EX_MEM/MEM_WR forwarding to any depth and register count.

---
 rtl/pipe_scoreboard.sv | 89 ++++++++
 tb/tb_pipe_scoreboard.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: tracks pending register writes across DEPTH
// post-decode stages and derives forwarding selects, load-use stall and a stall count.
module pipe_scoreboard #(
  parameter int NREG     = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 31,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1),
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_regwrite,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] src_a,
  input  logic              src_a_used,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              src_b_used,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0]             ent_v;
  logic [DEPTH-1:0]             ent_ld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
  logic                         haz_a;
  logic                         haz_b;
  logic                         accept;
  logic                         writes;

  // Returns {hazard, select}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SEL_W:0] lookup(
    input logic [ADDR_W-1:0]             s,
    input logic                          u,
    input logic [DEPTH-1:0]              v,
    input logic [DEPTH-1:0][ADDR_W-1:0]  rds,
    input logic [DEPTH-1:0]              lds
  );
    logic [SEL_W:0] r;
    r = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (u && (s != ZR) && v[k] && (rds[k] == s))
        r = {lds[k] && (k < LOAD_LAT), SEL_W'(k + 1)};
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign {haz_a, fwd_sel_a} = lookup(src_a, src_a_used, ent_v, ent_rd, ent_ld);
  assign {haz_b, fwd_sel_b} = lookup(src_b, src_b_used, ent_v, ent_rd, ent_ld);

  assign stall  = issue_valid && !flush && (haz_a || haz_b);
  assign busy   = |ent_v;
  assign accept = issue_valid && !stall && !flush;
  // Indices beyond the architectural file and the hard-zero register never produce.
  assign writes = issue_regwrite && (issue_rd != ZR) && (32'(issue_rd) < NREG);

  // Stage boundary: decode -> entry 0, entry k -> entry k+1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_v       <= '0;
      stall_count <= '0;
    end else begin
      ent_v <= (ent_v << 1) | DEPTH'(accept && writes);
      if (stall)
        stall_count <= sat_inc(stall_count);
    end
  end

  always_ff @(posedge clk) begin
    ent_ld <= (ent_ld << 1) | DEPTH'(issue_is_load);
    for (int k = DEPTH - 1; k >= 1; k--)
      ent_rd[k] <= ent_rd[k-1];
    ent_rd[0] <= issue_rd;
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: three instances (default, CNT_W=2, DEPTH=5) share one
// stimulus stream and are checked against an instruction-history reference model.
module tb_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_regwrite, issue_is_load;
  logic [4:0] issue_rd, src_a, src_b;
  logic       src_a_used, src_b_used, flush;

  logic [1:0]  fa3, fb3;
  logic        st3, by3;
  logic [15:0] cn3;
  logic [1:0]  fac, fbc;
  logic        stc, byc;
  logic [1:0]  cnc;
  logic [2:0]  fa5, fb5;
  logic        st5, by5;
  logic [15:0] cn5;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_scoreboard u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
    .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
    .flush(flush), .fwd_sel_a(fa3), .fwd_sel_b(fb3), .stall(st3), .busy(by3),
    .stall_count(cn3));

  pipe_scoreboard #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
    .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
    .flush(flush), .fwd_sel_a(fac), .fwd_sel_b(fbc), .stall(stc), .busy(byc),
    .stall_count(cnc));

  pipe_scoreboard #(.DEPTH(5)) u_d5 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
    .src_a(src_a), .src_a_used(src_a_used), .src_b(src_b), .src_b_used(src_b_used),
    .flush(flush), .fwd_sel_a(fa5), .fwd_sel_b(fb5), .stall(st5), .busy(by5),
    .stall_count(cn5));

  // Reference model: history of issued instructions, index 0 = most recently issued.
  typedef struct {
    bit       w;
    bit [4:0] rd;
    bit       ld;
  } rec_t;

  rec_t       hist[$];
  int         cnt16, cnt2;
  logic [1:0] e_fa3, e_fb3;
  logic [2:0] e_fa5, e_fb5;
  logic       e_stall, e_busy3, e_busy5;

  function automatic void find(input int d, input bit [4:0] s, input bit u,
                               output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (!u || s == 5'd31) return;
    for (int k = 0; k < hist.size() && k < d; k++) begin
      if (hist[k].w && hist[k].rd == s) begin
        sel = k + 1;
        haz = hist[k].ld && (k < 1);
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    int s;
    bit ha, hb, hx;
    find(3, src_a, src_a_used, s, ha); e_fa3 = 2'(s);
    find(3, src_b, src_b_used, s, hb); e_fb3 = 2'(s);
    find(5, src_a, src_a_used, s, hx); e_fa5 = 3'(s);
    find(5, src_b, src_b_used, s, hx); e_fb5 = 3'(s);
    e_stall = issue_valid && !flush && (ha || hb);
    e_busy3 = 1'b0;
    e_busy5 = 1'b0;
    for (int k = 0; k < hist.size(); k++) begin
      if (hist[k].w && k < 3) e_busy3 = 1'b1;
      if (hist[k].w && k < 5) e_busy5 = 1'b1;
    end
  endfunction

  task automatic apply(input bit v, input bit [4:0] rd, input bit rw, input bit ld,
                       input bit [4:0] sa, input bit sau, input bit [4:0] sb,
                       input bit sbu, input bit fl);
    #1;
    issue_valid = v; issue_rd = rd; issue_regwrite = rw; issue_is_load = ld;
    src_a = sa; src_a_used = sau; src_b = sb; src_b_used = sbu; flush = fl;
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    rec_t r;
    model_eval();
    if (e_stall) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
    r.w  = issue_valid && !e_stall && !flush && issue_regwrite && issue_rd != 5'd31;
    r.rd = issue_rd;
    r.ld = issue_is_load;
    hist.push_front(r);
    if (hist.size() > 8) void'(hist.pop_back());
    @(posedge clk);
  endtask

  task automatic bubble();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    issue_valid = 0; issue_rd = 0; issue_regwrite = 0; issue_is_load = 0;
    src_a = 0; src_a_used = 0; src_b = 0; src_b_used = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (st3 !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", st3); end
    vectors++; if (by3 !== 1'b0 || by5 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b/%b want 0", by3, by5); end
    vectors++; if (fa3 !== 2'd0 || fb3 !== 2'd0) begin miscompares++; $display("FAIL reset_fwd got %0d/%0d want 0", fa3, fb3); end
    vectors++; if (cn3 !== 16'd0 || cnc !== 2'd0) begin miscompares++; $display("FAIL reset_count got %0d/%0d want 0", cn3, cnc); end
    @(negedge clk);
    #2 reset = 1'b1;
    hist.delete(); cnt16 = 0; cnt2 = 0;
    @(posedge clk);
  endtask

  task automatic test_forward();
    apply(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 4, 1, 0, 1, 1, 0, 0, 0);
    vectors++; if (fa3 !== 2'd1) begin miscompares++; $display("FAIL fwd_ex got %0d want 1", fa3); end
    vectors++; if (st3 !== 1'b0) begin miscompares++; $display("FAIL fwd_ex_stall got %b want 0", st3); end
    tick();
    apply(1, 5, 1, 0, 1, 1, 0, 0, 0);
    vectors++; if (fa3 !== 2'd2 || fa5 !== 3'd2) begin miscompares++; $display("FAIL fwd_mem got %0d/%0d want 2", fa3, fa5); end
    tick();
    apply(1, 6, 1, 0, 0, 0, 0, 0, 0); tick();
    bubble();
    apply(1, 20, 1, 0, 0, 0, 6, 1, 0);
    vectors++; if (fb3 !== 2'd2) begin miscompares++; $display("FAIL fwd_after_bubble got %0d want 2", fb3); end
    tick();
  endtask

  task automatic test_load_use();
    apply(1, 2, 1, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 7, 1, 0, 0, 0, 2, 1, 0);
    vectors++; if (st3 !== 1'b1) begin miscompares++; $display("FAIL load_use_stall got %b want 1", st3); end
    tick();
    apply(1, 7, 1, 0, 0, 0, 2, 1, 0);
    vectors++; if (st3 !== 1'b0) begin miscompares++; $display("FAIL retry_stall got %b want 0", st3); end
    vectors++; if (fb3 !== 2'd2) begin miscompares++; $display("FAIL retry_fwd got %0d want 2", fb3); end
    vectors++; if (cn3 !== 16'd1 || cnc !== 2'd1) begin miscompares++; $display("FAIL stall_count got %0d/%0d want 1", cn3, cnc); end
    tick();
  endtask

  task automatic test_youngest();
    apply(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 8, 1, 0, 3, 1, 0, 0, 0);
    vectors++; if (fa3 !== 2'd1) begin miscompares++; $display("FAIL youngest got %0d want 1", fa3); end
    tick();
  endtask

  task automatic test_zero_reg();
    apply(1, 31, 1, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 9, 1, 0, 31, 1, 0, 0, 0);
    vectors++; if (fa3 !== 2'd0 || st3 !== 1'b0) begin miscompares++; $display("FAIL zero_reg got fwd %0d stall %b want 0/0", fa3, st3); end
    tick();
    apply(1, 31, 1, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 9, 1, 0, 0, 0, 31, 1, 0);
    vectors++; if (st3 !== 1'b0) begin miscompares++; $display("FAIL zero_reg_load got %b want 0", st3); end
    tick();
  endtask

  task automatic test_flush();
    repeat (3) bubble();
    apply(1, 10, 1, 1, 0, 0, 0, 0, 0);
    vectors++; if (by3 !== 1'b0) begin miscompares++; $display("FAIL drained_busy got %b want 0", by3); end
    tick();
    apply(1, 11, 1, 1, 10, 1, 0, 0, 1);
    vectors++; if (st3 !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", st3); end
    tick();
    apply(1, 12, 0, 0, 11, 1, 0, 0, 0);
    vectors++; if (fa3 !== 2'd0 || st3 !== 1'b0) begin miscompares++; $display("FAIL flush_bubble got fwd %0d stall %b want 0/0", fa3, st3); end
    vectors++; if (by3 !== 1'b1) begin miscompares++; $display("FAIL flush_busy1 got %b want 1", by3); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (by3 !== 1'b1) begin miscompares++; $display("FAIL flush_busy2 got %b want 1", by3); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (by3 !== 1'b0 || by5 !== 1'b1) begin miscompares++; $display("FAIL flush_busy3 got %b/%b want 0/1", by3, by5); end
    tick();
  endtask

  task automatic test_self();
    repeat (5) bubble();
    apply(1, 13, 1, 0, 13, 1, 13, 1, 0);
    vectors++; if (fa3 !== 2'd0 || fb3 !== 2'd0 || st3 !== 1'b0) begin miscompares++; $display("FAIL self got %0d/%0d/%b want 0/0/0", fa3, fb3, st3); end
    tick();
    apply(1, 21, 1, 0, 13, 1, 0, 0, 0);
    vectors++; if (fa3 !== 2'd1) begin miscompares++; $display("FAIL self_next got %0d want 1", fa3); end
    tick();
  endtask

  task automatic test_depth5();
    apply(1, 14, 1, 0, 0, 0, 0, 0, 0); tick();
    repeat (3) bubble();
    apply(1, 22, 0, 0, 14, 1, 0, 0, 0);
    vectors++; if (fa5 !== 3'd4) begin miscompares++; $display("FAIL depth5_fwd got %0d want 4", fa5); end
    vectors++; if (fa3 !== 2'd0) begin miscompares++; $display("FAIL depth3_retired got %0d want 0", fa3); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply(1, 15, 1, 1, 0, 0, 0, 0, 0); tick();
    apply(1, 16, 1, 0, 15, 1, 0, 0, 0);
    vectors++; if (st3 !== 1'b1) begin miscompares++; $display("FAIL pre_reset_stall got %b want 1", st3); end
    #2 reset = 1'b0;
    hist.delete(); cnt16 = 0; cnt2 = 0;
    #1;
    vectors++; if (st3 !== 1'b0 || by3 !== 1'b0 || by5 !== 1'b0) begin miscompares++; $display("FAIL async_reset got stall %b busy %b/%b want 0", st3, by3, by5); end
    vectors++; if (fa3 !== 2'd0 || fa5 !== 3'd0) begin miscompares++; $display("FAIL async_reset_fwd got %0d/%0d want 0", fa3, fa5); end
    vectors++; if (cn3 !== 16'd0 || cnc !== 2'd0) begin miscompares++; $display("FAIL async_reset_count got %0d/%0d want 0", cn3, cnc); end
    #1 reset = 1'b1;
    #0;
    vectors++; if (st3 !== 1'b0 || fa3 !== 2'd0) begin miscompares++; $display("FAIL post_release got stall %b fwd %0d want 0/0", st3, fa3); end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      apply(1, 17, 1, 1, 0, 0, 0, 0, 0); tick();
      apply(1, 18, 0, 0, 17, 1, 0, 0, 0);
      vectors++; if (st3 !== 1'b1) begin miscompares++; $display("FAIL sat_stall%0d got %b want 1", i, st3); end
      tick();
      apply(1, 18, 0, 0, 17, 1, 0, 0, 0); tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (cnc !== 2'd3) begin miscompares++; $display("FAIL sat_count got %0d want 3", cnc); end
    vectors++; if (cn3 !== 16'd5) begin miscompares++; $display("FAIL wide_count got %0d want 5", cn3); end
    tick();
  endtask

  task automatic test_random();
    bit v, rw, ld, sau, sbu, fl, hold;
    bit [4:0] rd, sa, sb;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 9) != 0);
        rd  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
        rw  = ($urandom_range(0, 4) != 0);
        ld  = ($urandom_range(0, 2) == 0);
        sa  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
        sb  = 5'($urandom_range(0, 5));
        sau = ($urandom_range(0, 3) != 0);
        sbu = ($urandom_range(0, 2) != 0);
        fl  = ($urandom_range(0, 9) == 0);
      end
      apply(v, rd, rw, ld, sa, sau, sb, sbu, fl);
      vectors++; if (fa3 !== e_fa3) begin miscompares++; $display("FAIL rnd_fwd_a cyc %0d got %0d want %0d", n, fa3, e_fa3); end
      vectors++; if (fb3 !== e_fb3) begin miscompares++; $display("FAIL rnd_fwd_b cyc %0d got %0d want %0d", n, fb3, e_fb3); end
      vectors++; if (st3 !== e_stall) begin miscompares++; $display("FAIL rnd_stall cyc %0d got %b want %b", n, st3, e_stall); end
      vectors++; if (by3 !== e_busy3) begin miscompares++; $display("FAIL rnd_busy cyc %0d got %b want %b", n, by3, e_busy3); end
      vectors++; if (cn3 !== 16'(cnt16)) begin miscompares++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, cn3, cnt16); end
      vectors++; if (cnc !== 2'(cnt2) || stc !== e_stall) begin miscompares++; $display("FAIL rnd_c2 cyc %0d got cnt %0d stall %b want %0d/%b", n, cnc, stc, cnt2, e_stall); end
      vectors++; if (fa5 !== e_fa5 || fb5 !== e_fb5) begin miscompares++; $display("FAIL rnd_d5_fwd cyc %0d got %0d/%0d want %0d/%0d", n, fa5, fb5, e_fa5, e_fb5); end
      vectors++; if (by5 !== e_busy5 || st5 !== e_stall) begin miscompares++; $display("FAIL rnd_d5_ctl cyc %0d got busy %b stall %b want %b/%b", n, by5, st5, e_busy5, e_stall); end
      hold = e_stall;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_flush();
    test_self();
    test_depth5();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
